// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared mode encodings for the multi-channel breathing PWM
package rgb_pwm_pkg;
   localparam int MODE_W = 2;
   localparam logic [MODE_W-1:0] MODE_STATIC = 2'd0;
   localparam logic [MODE_W-1:0] MODE_TRI    = 2'd1;
   localparam logic [MODE_W-1:0] MODE_SAW    = 2'd2;
endpackage

// File: rtl/pwm_ramp.sv
// rtl/pwm_ramp.sv - one channel's duty register and direction flag, updated at period boundaries
module pwm_ramp
   import rgb_pwm_pkg::*;
#(
   parameter int CNT_W     = 13,
   parameter int STEP_W    = 4,
   parameter int DUTY_MAX  = 8000,
   parameter int INIT_DUTY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boundary,
   input  logic [MODE_W-1:0] mode,
   input  logic [STEP_W-1:0] step,
   input  logic [CNT_W-1:0]  duty_static,
   output logic [CNT_W-1:0]  duty,
   output logic              up_down
);
   localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(DUTY_MAX);

   logic [CNT_W-1:0] duty_q, duty_d;
   logic             up_q, up_d;
   logic [CNT_W:0]   step_ext;
   logic [CNT_W:0]   sum;

   // One extra bit so a rising ramp near the ceiling can never wrap to a small value.
   assign step_ext = (CNT_W+1)'(step);
   assign sum      = {1'b0, duty_q} + step_ext;

   always_comb begin
      duty_d = duty_q;
      up_d   = up_q;
      if (boundary && (step != '0)) begin
         case (mode)
            MODE_TRI: begin
               if (up_q) begin
                  if (sum >= MAX_EXT) begin
                     duty_d = MAX_EXT[CNT_W-1:0];
                     up_d   = 1'b0;
                  end else begin
                     duty_d = sum[CNT_W-1:0];
                  end
               end else begin
                  if ({1'b0, duty_q} <= step_ext) begin
                     duty_d = '0;
                     up_d   = 1'b1;
                  end else begin
                     duty_d = duty_q - step_ext[CNT_W-1:0];
                  end
               end
            end
            MODE_SAW: begin
               duty_d = (sum > MAX_EXT) ? '0 : sum[CNT_W-1:0];
               up_d   = 1'b1;
            end
            default: begin
               duty_d = (duty_static > MAX_EXT[CNT_W-1:0]) ? MAX_EXT[CNT_W-1:0] : duty_static;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q <= CNT_W'(INIT_DUTY);
         up_q   <= 1'b1;
      end else begin
         duty_q <= duty_d;
         up_q   <= up_d;
      end
   end

   assign duty    = duty_q;
   assign up_down = up_q;
endmodule

// File: rtl/rgb_breath_pwm.sv
// rtl/rgb_breath_pwm.sv - shared period counter, per-channel duty ramps and registered PWM compare
module rgb_breath_pwm
   import rgb_pwm_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int CNT_W    = 13,
   parameter int PERIOD   = 8190,
   parameter int DUTY_MAX = 8000,
   parameter int STEP_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [MODE_W-1:0]         mode,
   input  logic [CHANNELS*CNT_W-1:0] duty_static,
   input  logic [STEP_W-1:0]         step,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic [CHANNELS-1:0]       up_down,
   output logic                      period_tick
);
   localparam logic [CNT_W-1:0] TERM    = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tick_q, tick_d;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                boundary;
   logic [CNT_W-1:0]    duty [CHANNELS];

   assign boundary = en && (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
      end
      // Registered so the pulse lines up with the cycle where cnt sits at PERIOD.
      tick_d = en && (cnt_q == TERM_M1);
   end

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
         pwm_ramp #(
            .CNT_W    (CNT_W),
            .STEP_W   (STEP_W),
            .DUTY_MAX (DUTY_MAX),
            .INIT_DUTY((k * DUTY_MAX) / CHANNELS)
         ) u_ramp (
            .clk        (clk),
            .rst_n      (rst_n),
            .boundary   (boundary),
            .mode       (mode),
            .step       (step),
            .duty_static(duty_static[k*CNT_W +: CNT_W]),
            .duty       (duty[k]),
            .up_down    (up_down[k])
         );
      end
   endgenerate

   always_comb begin
      pwm_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         pwm_d[k] = en && (cnt_q < duty[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         pwm_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = tick_q;
endmodule
